// File: rtl/moldudp64_header_if.sv
// Stream bundle between the UDP payload source and the MoldUDP64 header stripper.
// The master drives the *_i beat and receives the forwarded *_o beat.
interface moldudp64_header_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8
);
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic [KEEP_W-1:0] keep_i;
    logic              last_i;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic [KEEP_W-1:0] keep_o;
    logic              last_o;
    logic              init_v_o;

    modport master (
        output valid_i, data_i, keep_i, last_i,
        input  valid_o, data_o, keep_o, last_o, init_v_o
    );

    modport slave (
        input  valid_i, data_i, keep_i, last_i,
        output valid_o, data_o, keep_o, last_o, init_v_o
    );
endinterface

// File: rtl/moldudp64_header.sv
// Strips the 20-byte MoldUDP64 header from a 64-bit payload stream, tracks the
// expected sequence number per session and drops fully duplicate packets.
module moldudp64_header #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = 8,
    parameter int SID_W      = 80,
    parameter int SEQ_W      = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    moldudp64_header_if.slave s_if,
    output logic [SID_W-1:0] sid_o,
    output logic [SEQ_W-1:0] seq_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             hdr_v_o,
    output logic             gap_v_o,
    output logic             dup_v_o,
    output logic             hb_v_o,
    output logic             eos_v_o,
    output logic             err_v_o
);

    typedef enum logic [1:0] {
        H0 = 2'd0,
        H1 = 2'd1,
        H2 = 2'd2,
        PL = 2'd3
    } state_t;

    // Byte 0 of the beat is the most significant byte of every header field.
    function automatic logic [63:0] bswap64(input logic [63:0] d);
        logic [63:0] r;
        for (int n = 0; n < 8; n++) begin
            r[63-8*n -: 8] = d[8*n +: 8];
        end
        return r;
    endfunction

    state_t       r_state;
    logic         r_drop;
    logic [63:0]  r_sid_hi;
    logic [15:0]  r_sid_lo;
    logic [47:0]  r_seq_hi;
    logic [79:0]  r_sess_sid;
    logic [63:0]  r_exp;
    logic         r_exp_v;

    logic [63:0]  w_be;
    logic [79:0]  w_sid;
    logic [63:0]  w_seq;
    logic [15:0]  w_cnt;
    logic [63:0]  w_sum;
    logic         w_hb;
    logic         w_eos;
    logic         w_new;
    logic         w_gap;
    logic         w_dup;
    logic         w_runt;
    logic         w_fwd;

    // Header fields assembled from the H2 beat and the sequence decision on it.
    always_comb begin
        w_be   = bswap64(s_if.data_i);
        w_sid  = {r_sid_hi, r_sid_lo};
        w_seq  = {r_seq_hi, w_be[63:48]};
        w_cnt  = w_be[47:32];
        w_sum  = w_seq + {48'd0, w_cnt};
        w_hb   = (w_cnt == 16'h0000);
        w_eos  = (w_cnt == 16'hFFFF);
        w_new  = !r_exp_v || (w_sid != r_sess_sid);
        w_gap  = 1'b0;
        w_dup  = 1'b0;
        if (w_new) begin
            w_gap = 1'b0;
            w_dup = 1'b0;
        end else if (w_seq > r_exp) begin
            w_gap = 1'b1;
        end else if ((w_seq < r_exp) && (w_sum <= r_exp)) begin
            w_dup = 1'b1;
        end else begin
            w_gap = 1'b0;
            w_dup = 1'b0;
        end
        w_runt = s_if.last_i && (s_if.keep_i != 8'h0F) && w_hb;
        w_fwd  = !w_dup && !w_hb && !w_eos;
    end

    // Header parse FSM, expected-sequence tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= H0;
            r_drop        <= 1'b0;
            r_sid_hi      <= 64'd0;
            r_sid_lo      <= 16'd0;
            r_seq_hi      <= 48'd0;
            r_sess_sid    <= 80'd0;
            r_exp         <= 64'd0;
            r_exp_v       <= 1'b0;
            s_if.valid_o  <= 1'b0;
            s_if.data_o   <= 64'd0;
            s_if.keep_o   <= 8'd0;
            s_if.last_o   <= 1'b0;
            s_if.init_v_o <= 1'b0;
            sid_o         <= 80'd0;
            seq_o         <= 64'd0;
            cnt_o         <= 16'd0;
            hdr_v_o       <= 1'b0;
            gap_v_o       <= 1'b0;
            dup_v_o       <= 1'b0;
            hb_v_o        <= 1'b0;
            eos_v_o       <= 1'b0;
            err_v_o       <= 1'b0;
        end else begin
            s_if.valid_o  <= 1'b0;
            s_if.last_o   <= 1'b0;
            s_if.init_v_o <= 1'b0;
            hdr_v_o       <= 1'b0;
            gap_v_o       <= 1'b0;
            dup_v_o       <= 1'b0;
            hb_v_o        <= 1'b0;
            eos_v_o       <= 1'b0;
            err_v_o       <= 1'b0;
            if (s_if.valid_i) begin
                case (r_state)
                    H0: begin
                        if (s_if.last_i) begin
                            err_v_o <= 1'b1;
                            r_state <= H0;
                        end else begin
                            r_sid_hi <= w_be;
                            r_state  <= H1;
                        end
                    end
                    H1: begin
                        if (s_if.last_i) begin
                            err_v_o <= 1'b1;
                            r_state <= H0;
                        end else begin
                            r_sid_lo <= w_be[63:48];
                            r_seq_hi <= w_be[47:0];
                            r_state  <= H2;
                        end
                    end
                    H2: begin
                        if (w_runt) begin
                            err_v_o <= 1'b1;
                            r_state <= H0;
                        end else begin
                            hdr_v_o <= 1'b1;
                            gap_v_o <= w_gap;
                            dup_v_o <= w_dup;
                            hb_v_o  <= w_hb;
                            eos_v_o <= w_eos;
                            sid_o   <= w_sid;
                            seq_o   <= w_seq;
                            cnt_o   <= w_cnt;
                            if (!w_dup) begin
                                r_sess_sid <= w_sid;
                                r_exp      <= w_sum;
                                r_exp_v    <= !w_eos;
                            end else if (w_eos) begin
                                r_exp_v <= 1'b0;
                            end
                            if (w_fwd) begin
                                s_if.valid_o  <= 1'b1;
                                s_if.init_v_o <= 1'b1;
                                s_if.data_o   <= s_if.data_i;
                                s_if.keep_o   <= s_if.keep_i;
                                s_if.last_o   <= s_if.last_i;
                            end
                            // Packets with nothing to forward swallow their tail beats.
                            r_drop  <= !w_fwd;
                            r_state <= s_if.last_i ? H0 : PL;
                        end
                    end
                    PL: begin
                        if (!r_drop) begin
                            s_if.valid_o <= 1'b1;
                            s_if.data_o  <= s_if.data_i;
                            s_if.keep_o  <= s_if.keep_i;
                            s_if.last_o  <= s_if.last_i;
                        end
                        if (s_if.last_i) begin
                            r_state <= H0;
                            r_drop  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= H0;
                        r_drop  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_moldudp64_header.sv
// Randomized bench for moldudp64_header: packets are built as byte lists and the
// expected beats/header events come from a packet-level sequence model.
module tb_moldudp64_header;

    logic        clk;
    logic        reset;
    logic [79:0] sid_o;
    logic [63:0] seq_o;
    logic [15:0] cnt_o;
    logic        hdr_v_o, gap_v_o, dup_v_o, hb_v_o, eos_v_o, err_v_o;

    moldudp64_header_if #(.DATA_W(64), .KEEP_W(8)) bus ();

    moldudp64_header dut (
        .clk     (clk),
        .reset   (reset),
        .s_if    (bus),
        .sid_o   (sid_o),
        .seq_o   (seq_o),
        .cnt_o   (cnt_o),
        .hdr_v_o (hdr_v_o),
        .gap_v_o (gap_v_o),
        .dup_v_o (dup_v_o),
        .hb_v_o  (hb_v_o),
        .eos_v_o (eos_v_o),
        .err_v_o (err_v_o)
    );

    typedef struct {
        int          cyc;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        i;
    } beat_t;

    typedef struct {
        int          cyc;
        logic [79:0] sid;
        logic [63:0] seq;
        logic [15:0] cnt;
        logic        gap;
        logic        dup;
        logic        hb;
        logic        eos;
        logic        fwd;
    } hdr_t;

    beat_t bq[$];
    hdr_t  hq[$];
    int    eq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic mon_en = 1'b0;

    // Expected-sequence model state.
    logic        m_v   = 1'b0;
    logic [63:0] m_e   = 64'd0;
    logic [79:0] m_sid = 80'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic idle();
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Build a packet, predict its outcome and drive its beats with random idles.
    task automatic send_pkt(input logic [79:0] sid, input logic [63:0] seq,
                            input logic [15:0] cnt, input int nmsg, input int runt_beat);
        logic [7:0]  pb[$];
        int          nbeats;
        int          len;
        logic [63:0] sum;
        hdr_t        h;
        beat_t       b;
        logic [63:0] d;
        logic [7:0]  k;
        for (int i = 0; i < 10; i++) pb.push_back(sid[79-8*i -: 8]);
        for (int i = 0; i < 8; i++)  pb.push_back(seq[63-8*i -: 8]);
        pb.push_back(cnt[15:8]);
        pb.push_back(cnt[7:0]);
        for (int m = 0; m < nmsg; m++) begin
            len = $urandom_range(1, 12);
            pb.push_back(8'd0);
            pb.push_back(8'(len));
            for (int j = 0; j < len; j++) pb.push_back(8'($urandom()));
        end
        nbeats = (pb.size() + 7) / 8;
        if (runt_beat >= 0) nbeats = runt_beat + 1;

        h.sid = sid; h.seq = seq; h.cnt = cnt;
        h.hb  = (cnt == 16'h0000);
        h.eos = (cnt == 16'hFFFF);
        h.gap = 1'b0; h.dup = 1'b0;
        sum   = seq + 64'(cnt);
        if (runt_beat < 0) begin
            if (m_v && sid == m_sid) begin
                if (seq > m_e) h.gap = 1'b1;
                if (seq < m_e && sum <= m_e) h.dup = 1'b1;
            end
            if (!h.dup) begin
                m_sid = sid;
                m_e   = sum;
                m_v   = 1'b1;
            end
            if (h.eos) m_v = 1'b0;
        end
        h.fwd = !h.dup && !h.hb && !h.eos;

        for (int bi = 0; bi < nbeats; bi++) begin
            repeat ($urandom_range(0, 2)) idle();
            d = 64'd0;
            k = 8'd0;
            for (int j = 0; j < 8; j++) begin
                if (8*bi + j < pb.size()) begin
                    d[8*j +: 8] = pb[8*bi + j];
                    k[j] = 1'b1;
                end
            end
            bus.valid_i = 1'b1;
            bus.data_i  = d;
            bus.keep_i  = k;
            bus.last_i  = (bi == nbeats - 1);
            if (runt_beat >= 0) begin
                if (bi == nbeats - 1) eq.push_back(cyc + 1);
            end else begin
                if (bi == 2) begin
                    h.cyc = cyc + 1;
                    hq.push_back(h);
                end
                if (bi >= 2 && h.fwd) begin
                    b.cyc = cyc + 1; b.d = d; b.k = k;
                    b.l = (bi == nbeats - 1);
                    b.i = (bi == 2);
                    bq.push_back(b);
                end
            end
            @(posedge clk);
            #1;
            bus.valid_i = 1'b0;
            bus.last_i  = 1'b0;
        end
    endtask

    // Output monitor: every DUT event must match the head of its expectation queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.valid_o) begin
                if (bq.size() == 0) begin
                    check_eq("spurious_valid_o", bus.valid_o, 1'b0);
                end else begin
                    beat_t e;
                    e = bq.pop_front();
                    check_eq("beat_cycle", cyc, e.cyc);
                    check_eq("data_o", bus.data_o, e.d);
                    check_eq("keep_o", bus.keep_o, e.k);
                    check_eq("last_o", bus.last_o, e.l);
                    check_eq("init_v_o", bus.init_v_o, e.i);
                end
            end
            if (bus.init_v_o && !bus.valid_o) check_eq("init_wo_valid", bus.init_v_o, 1'b0);
            if (hdr_v_o) begin
                if (hq.size() == 0) begin
                    check_eq("spurious_hdr_v_o", hdr_v_o, 1'b0);
                end else begin
                    hdr_t e;
                    e = hq.pop_front();
                    check_eq("hdr_cycle", cyc, e.cyc);
                    check_eq("sid_o", sid_o, e.sid);
                    check_eq("seq_o", seq_o, e.seq);
                    check_eq("cnt_o", cnt_o, e.cnt);
                    check_eq("gap_v_o", gap_v_o, e.gap);
                    check_eq("dup_v_o", dup_v_o, e.dup);
                    check_eq("hb_v_o", hb_v_o, e.hb);
                    check_eq("eos_v_o", eos_v_o, e.eos);
                    check_eq("hdr_fwd", bus.valid_o & bus.init_v_o, e.fwd);
                end
            end else if (gap_v_o | dup_v_o | hb_v_o | eos_v_o) begin
                check_eq("flag_wo_hdr", {gap_v_o, dup_v_o, hb_v_o, eos_v_o}, 4'd0);
            end
            if (err_v_o) begin
                if (eq.size() == 0) begin
                    check_eq("spurious_err_v_o", err_v_o, 1'b0);
                end else begin
                    check_eq("err_cycle", cyc, eq.pop_front());
                end
            end
        end
    end

    initial begin
        logic [79:0] sid_a;
        logic [79:0] sid_b;
        logic [79:0] s;
        logic [63:0] q;
        logic [15:0] c;
        int          off;
        int          r;
        int          rb;

        sid_a = 80'h0102030405060708090A;
        sid_b = 80'hA5A5_0000_1111_2222_3333;
        reset = 1'b1;
        bus.valid_i = 1'b0;
        bus.data_i  = 64'd0;
        bus.keep_i  = 8'd0;
        bus.last_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid_o", bus.valid_o, 1'b0);
        check_eq("rst_init_v_o", bus.init_v_o, 1'b0);
        check_eq("rst_last_o", bus.last_o, 1'b0);
        check_eq("rst_data_o", bus.data_o, 64'd0);
        check_eq("rst_keep_o", bus.keep_o, 8'd0);
        check_eq("rst_sid_o", sid_o, 80'd0);
        check_eq("rst_seq_o", seq_o, 64'd0);
        check_eq("rst_cnt_o", cnt_o, 16'd0);
        check_eq("rst_pulses", {hdr_v_o, gap_v_o, dup_v_o, hb_v_o, eos_v_o, err_v_o}, 6'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed walk through the main sequence scenarios.
        send_pkt(sid_a, 64'd100, 16'd2, 2, -1);
        send_pkt(sid_a, 64'd105, 16'd1, 1, -1);
        send_pkt(sid_a, 64'd100, 16'd2, 2, -1);
        send_pkt(sid_a, 64'd106, 16'd0, 0, -1);
        send_pkt(sid_a, 64'd106, 16'hFFFF, 0, -1);
        send_pkt(sid_a, 64'd500, 16'd1, 1, -1);
        send_pkt(sid_a, 64'd501, 16'd2, 2, 1);
        send_pkt(sid_a, 64'd501, 16'd2, 2, 0);
        send_pkt(sid_a, 64'd501, 16'd3, 3, -1);
        send_pkt(sid_b, 64'd1, 16'd2, 2, -1);
        send_pkt(sid_b, 64'hFFFF_FFFF_FFFF_FFFF, 16'd3, 3, -1);
        send_pkt(sid_b, 64'd2, 16'd1, 1, -1);
        send_pkt(sid_b, 64'd1, 16'd3, 3, -1);

        for (int p = 0; p < 250; p++) begin
            if (!m_v || $urandom_range(0, 9) == 0) begin
                s = ($urandom_range(0, 1) == 0) ? sid_a : sid_b;
                q = {$urandom(), $urandom()};
            end else begin
                s   = m_sid;
                off = int'($urandom_range(0, 8)) - 4;
                q   = (off >= 0) ? m_e + 64'(off) : m_e - 64'(-off);
            end
            r = $urandom_range(0, 19);
            if (r < 2)       c = 16'h0000;
            else if (r == 2) c = 16'hFFFF;
            else             c = 16'($urandom_range(1, 3));
            rb = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 1) : -1;
            send_pkt(s, q, c, (c == 16'hFFFF) ? 0 : int'(c), rb);
        end

        repeat (4) idle();
        check_eq("beats_left", bq.size(), 0);
        check_eq("hdrs_left", hq.size(), 0);
        check_eq("errs_left", eq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
